// File: rtl/burst_ram_arbiter_if.sv
// Bundle of both requester ports and the BurstRAM command/data port.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface burst_ram_arbiter_if #(
    parameter int ADDR_BITWIDTH = 8,
    parameter int DATA_BITWIDTH = 64
);
    localparam int MW = DATA_BITWIDTH / 8;

    logic                     m0_req;
    logic                     m0_cmd;
    logic [ADDR_BITWIDTH-1:0] m0_addr;
    logic [DATA_BITWIDTH-1:0] m0_wr_data;
    logic [MW-1:0]            m0_data_mask;
    logic                     m0_gnt;
    logic                     m0_rd_data_valid;

    logic                     m1_req;
    logic                     m1_cmd;
    logic [ADDR_BITWIDTH-1:0] m1_addr;
    logic [DATA_BITWIDTH-1:0] m1_wr_data;
    logic [MW-1:0]            m1_data_mask;
    logic                     m1_gnt;
    logic                     m1_rd_data_valid;

    logic [DATA_BITWIDTH-1:0] rd_data;

    logic                     br_cmd;
    logic                     br_cmd_en;
    logic [ADDR_BITWIDTH-1:0] br_addr;
    logic [DATA_BITWIDTH-1:0] br_wr_data;
    logic [MW-1:0]            br_data_mask;
    logic [DATA_BITWIDTH-1:0] br_rd_data;
    logic                     br_rd_data_valid;
    logic                     br_busy;

    modport slave (
        input  m0_req, m0_cmd, m0_addr, m0_wr_data, m0_data_mask,
        output m0_gnt, m0_rd_data_valid,
        input  m1_req, m1_cmd, m1_addr, m1_wr_data, m1_data_mask,
        output m1_gnt, m1_rd_data_valid,
        output rd_data,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        input  br_rd_data, br_rd_data_valid, br_busy
    );

    modport master (
        output m0_req, m0_cmd, m0_addr, m0_wr_data, m0_data_mask,
        input  m0_gnt, m0_rd_data_valid,
        output m1_req, m1_cmd, m1_addr, m1_wr_data, m1_data_mask,
        input  m1_gnt, m1_rd_data_valid,
        input  rd_data,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        output br_rd_data, br_rd_data_valid, br_busy
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM command port between the
// instruction cache (port 0) and data cache (port 1), one burst in flight.
module burst_ram_arbiter #(
    parameter int ADDR_BITWIDTH = 8,
    parameter int DATA_BITWIDTH = 64,
    parameter int BURST_COUNT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    burst_ram_arbiter_if.slave bus
);
    localparam int MW = DATA_BITWIDTH / 8;
    localparam int CW = $clog2(BURST_COUNT) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] beat_q, beat_d;

    logic                     own_cmd;
    logic [ADDR_BITWIDTH-1:0] own_addr;
    logic [DATA_BITWIDTH-1:0] own_wr_data;
    logic [MW-1:0]            own_mask;
    logic                     issue;
    logic                     drive;
    logic                     rd_beat;

    assign own_cmd     = owner_q ? bus.m1_cmd       : bus.m0_cmd;
    assign own_addr    = owner_q ? bus.m1_addr      : bus.m0_addr;
    assign own_wr_data = owner_q ? bus.m1_wr_data   : bus.m0_wr_data;
    assign own_mask    = owner_q ? bus.m1_data_mask : bus.m0_data_mask;

    assign issue   = (state_q == S_ISSUE);
    assign drive   = issue || (state_q == S_WRITE);
    assign rd_beat = (state_q == S_READ) && bus.br_rd_data_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.br_busy && (bus.m0_req || bus.m1_req)) begin
                    // Tie goes to the port that did not win last time.
                    owner_d = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                last_d = owner_q;
                beat_d = '0;
                if (!own_cmd) begin
                    state_d = S_READ;
                end else if (BURST_COUNT > 1) begin
                    state_d = S_WRITE;
                    beat_d  = CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
            S_READ: begin
                if (bus.br_rd_data_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.m0_gnt = issue && !owner_q;
    assign bus.m1_gnt = issue && owner_q;

    assign bus.m0_rd_data_valid = rd_beat && !owner_q;
    assign bus.m1_rd_data_valid = rd_beat && owner_q;
    assign bus.rd_data          = bus.br_rd_data;

    assign bus.br_cmd_en    = issue;
    assign bus.br_cmd       = drive && own_cmd;
    assign bus.br_addr      = drive ? own_addr    : '0;
    assign bus.br_wr_data   = drive ? own_wr_data : '0;
    assign bus.br_data_mask = drive ? own_mask    : '0;
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Randomized bench for burst_ram_arbiter against a burst-level reference
// model, plus directed scenarios for reset, alternation, writes and busy.
module tb_burst_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int BC = 4;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    burst_ram_arbiter_if #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus ();

    burst_ram_arbiter #(
        .ADDR_BITWIDTH(AW),
        .DATA_BITWIDTH(DW),
        .BURST_COUNT(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Burst-level model: pending issue, write beats left, read beats left.
    bit m_pend, m_own, m_last;
    int m_wr, m_rd;
    logic [1:0]    e_gnt, e_rdv;
    logic          e_en, e_cmd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [MW-1:0] e_mk;
    bit gs0, gs1;
    int rc0 = 0;
    int rc1 = 0;
    int glog[$];

    always @(negedge clk) begin
        e_gnt = '0; e_rdv = '0; e_en = 1'b0; e_cmd = 1'b0;
        e_addr = '0; e_wd = '0; e_mk = '0;
        if (!rst) begin
            m_pend = 0; m_wr = 0; m_rd = 0; m_own = 0; m_last = 1;
        end
        if (m_pend || m_wr > 0) begin
            e_wd = m_own ? bus.m1_wr_data : bus.m0_wr_data;
            e_mk = m_own ? bus.m1_data_mask : bus.m0_data_mask;
            if (m_pend) begin
                e_en = 1'b1;
                e_gnt[m_own] = 1'b1;
                e_cmd  = m_own ? bus.m1_cmd : bus.m0_cmd;
                e_addr = m_own ? bus.m1_addr : bus.m0_addr;
            end
        end else if (m_rd > 0 && bus.br_rd_data_valid) begin
            e_rdv[m_own] = 1'b1;
        end
        check_eq("m0_gnt", 64'(bus.m0_gnt), 64'(e_gnt[0]));
        check_eq("m1_gnt", 64'(bus.m1_gnt), 64'(e_gnt[1]));
        check_eq("br_cmd_en", 64'(bus.br_cmd_en), 64'(e_en));
        check_eq("m0_rdv", 64'(bus.m0_rd_data_valid), 64'(e_rdv[0]));
        check_eq("m1_rdv", 64'(bus.m1_rd_data_valid), 64'(e_rdv[1]));
        check_eq("br_wr_data", bus.br_wr_data, e_wd);
        check_eq("br_mask", 64'(bus.br_data_mask), 64'(e_mk));
        check_eq("rd_data", bus.rd_data, bus.br_rd_data);
        if (m_wr == 0) begin
            check_eq("br_cmd", 64'(bus.br_cmd), 64'(e_cmd));
            check_eq("br_addr", 64'(bus.br_addr), 64'(e_addr));
        end
        gs0 = bus.m0_gnt;
        gs1 = bus.m1_gnt;
        if (bus.m0_gnt) glog.push_back(0);
        if (bus.m1_gnt) glog.push_back(1);
        if (bus.m0_rd_data_valid) rc0++;
        if (bus.m1_rd_data_valid) rc1++;
        if (rst) begin
            if (m_pend) begin
                m_pend = 0;
                m_last = m_own;
                if (e_cmd) m_wr = BC - 1;
                else m_rd = BC;
            end else if (m_wr > 0) begin
                m_wr--;
            end else if (m_rd > 0) begin
                if (bus.br_rd_data_valid) m_rd--;
            end else if (!bus.br_busy && (bus.m0_req || bus.m1_req)) begin
                m_own = (bus.m0_req && bus.m1_req) ? !m_last : bus.m1_req;
                m_pend = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (gs0) bus.m0_req = 1'b0;
        if (gs1) bus.m1_req = 1'b0;
    endtask

    task automatic settle(input int n);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.br_busy = 1'b0;
        bus.br_rd_data_valid = 1'b1;
        repeat (n) step();
    endtask

    int base, base2;

    initial begin
        bus.m0_req = 0; bus.m0_cmd = 0; bus.m0_addr = '0;
        bus.m0_wr_data = '0; bus.m0_data_mask = '0;
        bus.m1_req = 0; bus.m1_cmd = 0; bus.m1_addr = '0;
        bus.m1_wr_data = '0; bus.m1_data_mask = '0;
        bus.br_rd_data = 64'h1234; bus.br_rd_data_valid = 1'b1;
        bus.br_busy = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // Read on port 0 only; valid also high in IDLE/ISSUE
        base = rc0; base2 = rc1;
        bus.m0_req = 1; bus.m0_cmd = 0; bus.m0_addr = 8'h10;
        repeat (10) step();
        check_eq("t1_m0_beats", 64'(rc0 - base), 64'(4));
        check_eq("t1_m1_beats", 64'(rc1 - base2), 64'(0));

        // Simultaneous pairs alternate, starting with port 0 after reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        base = glog.size();
        bus.m0_req = 1; bus.m0_cmd = 0; bus.m0_addr = 8'h01;
        bus.m1_req = 1; bus.m1_cmd = 0; bus.m1_addr = 8'h02;
        for (int i = 0; i < 40 && glog.size() - base < 2; i++) step();
        bus.m0_req = 1; bus.m1_req = 1;
        for (int i = 0; i < 40 && glog.size() - base < 3; i++) step();
        check_eq("t2_count", 64'(glog.size() - base), 64'(3));
        if (glog.size() - base >= 3) begin
            check_eq("t2_first", 64'(glog[base]), 64'(0));
            check_eq("t2_second", 64'(glog[base + 1]), 64'(1));
            check_eq("t2_third", 64'(glog[base + 2]), 64'(0));
        end
        for (int i = 0; i < 40 && bus.m1_req; i++) step();
        settle(12);

        // Port 1 write burst, beats 0xA..0xD
        bus.m1_req = 1; bus.m1_cmd = 1; bus.m1_addr = 8'h20;
        bus.m1_data_mask = '0; bus.m1_wr_data = 64'hA;
        step();
        for (int b = 0; b < BC; b++) begin
            bus.m1_wr_data = 64'(10 + b);
            #1;
            check_eq("t3_wdata", bus.br_wr_data, 64'(10 + b));
            check_eq("t3_cmd_en", 64'(bus.br_cmd_en), 64'(b == 0));
            check_eq("t3_cmd", 64'(bus.br_cmd), 64'(1));
            step();
        end
        settle(4);

        // br_busy blocks grants
        base = glog.size();
        bus.br_busy = 1; bus.m0_req = 1; bus.m0_cmd = 0; bus.m0_addr = 8'h40;
        repeat (5) step();
        check_eq("t4_no_gnt", 64'(glog.size() - base), 64'(0));
        bus.br_busy = 0;
        step();
        check_eq("t4_gnt", 64'(bus.m0_gnt), 64'(1));
        settle(10);

        // Reset in the middle of a read
        base = rc0;
        bus.m0_req = 1; bus.m0_cmd = 0; bus.m0_addr = 8'h33;
        for (int i = 0; i < 20 && rc0 - base < 2; i++) step();
        check_eq("t5_two_beats", 64'(rc0 - base), 64'(2));
        rst = 1'b0;
        #1;
        check_eq("t5_rdv", 64'(bus.m0_rd_data_valid), 64'(0));
        check_eq("t5_cmd_en", 64'(bus.br_cmd_en), 64'(0));
        check_eq("t5_addr", 64'(bus.br_addr), 64'(0));
        repeat (2) step();
        rst = 1'b1;
        base = rc0 + rc1;
        repeat (6) step();
        check_eq("t5_stale", 64'(rc0 + rc1 - base), 64'(0));
        base = glog.size(); base2 = rc1;
        bus.m1_req = 1; bus.m1_cmd = 0; bus.m1_addr = 8'h55;
        for (int i = 0; i < 20 && rc1 - base2 < 4; i++) step();
        check_eq("t5_next_gnt", 64'(glog.size() - base), 64'(1));
        check_eq("t5_next_beats", 64'(rc1 - base2), 64'(4));
        settle(4);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            if (!bus.m0_req && !gs0 && $urandom_range(3) == 0) begin
                bus.m0_req = 1;
                bus.m0_cmd = 1'($urandom_range(1));
                bus.m0_addr = AW'($urandom);
            end
            if (!bus.m1_req && !gs1 && $urandom_range(3) == 0) begin
                bus.m1_req = 1;
                bus.m1_cmd = 1'($urandom_range(1));
                bus.m1_addr = AW'($urandom);
            end
            bus.m0_wr_data = {$urandom, $urandom};
            bus.m1_wr_data = {$urandom, $urandom};
            bus.m0_data_mask = MW'($urandom);
            bus.m1_data_mask = MW'($urandom);
            bus.br_busy = ($urandom_range(4) == 0);
            bus.br_rd_data_valid = 1'($urandom_range(1));
            bus.br_rd_data = {$urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
